// File: rtl/sti_dac_pkg.sv
// sti_dac_pkg: shared configuration, FSM state type and pure helper
// functions for the serial transmitter / pixel packer.
//   frame_len   : pi_length code -> serial frame length in bits
//   build_frame : word + fill/low/msb -> FRAME_W vector, first bit at MSB
//   map_pixel   : pixel index -> bank, odd/even parity, word address
package sti_dac_pkg;

  localparam int DATA_W     = 16;
  localparam int PIX_W      = 8;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_DEPTH = 32;
  localparam int ROW_PIX    = 8;

  localparam int TOTAL_PIX = 2 * NUM_BANKS * BANK_DEPTH;
  localparam int BANK_SPAN = TOTAL_PIX / NUM_BANKS;
  localparam int FRAME_W   = 4 * PIX_W;
  localparam int ADDR_W    = $clog2(BANK_DEPTH);
  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int PCNT_W    = $clog2(TOTAL_PIX + 1);
  localparam int LEN_W     = $clog2(FRAME_W + 1);
  localparam int BITC_W    = $clog2(PIX_W);

  localparam logic [PCNT_W-1:0] TOTAL_P = PCNT_W'(TOTAL_PIX);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FLUSH, ST_DONE} state_e;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic              odd;
    logic [ADDR_W-1:0] addr;
  } map_t;

  function automatic logic [LEN_W-1:0] frame_len(input logic [1:0] length);
    return LEN_W'((int'(length) + 1) * PIX_W);
  endfunction

  // The transmitter always shifts from bit FRAME_W-1, so the returned
  // vector already carries the first serial bit at the top.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [DATA_W-1:0] data,
    input logic [1:0]        length,
    input logic              fill,
    input logic              low,
    input logic              msb
  );
    logic [FRAME_W-1:0] word;
    logic [FRAME_W-1:0] rev;
    int len;
    len = (int'(length) + 1) * PIX_W;
    if (len >= DATA_W) begin
      if (fill) word = FRAME_W'(data) << (len - DATA_W);
      else      word = FRAME_W'(data);
    end else begin
      if (low) word = FRAME_W'(data) & ((FRAME_W'(1) << len) - FRAME_W'(1));
      else     word = FRAME_W'(data >> (DATA_W - len));
    end
    // word is zero above len, so a full reversal leaves bit 0 on top
    // and the len-bit field occupying the upper positions.
    for (int i = 0; i < FRAME_W; i++) rev[i] = word[FRAME_W-1-i];
    return msb ? (word << (FRAME_W - len)) : rev;
  endfunction

  function automatic map_t map_pixel(input logic [PCNT_W-1:0] p);
    map_t m;
    int pi;
    pi     = int'(p);
    m.bank = BANK_W'(pi / BANK_SPAN);
    m.addr = ADDR_W'((pi % BANK_SPAN) >> 1);
    m.odd  = 1'(((pi / ROW_PIX) ^ (pi % ROW_PIX)) & 1);
    return m;
  endfunction

endpackage

// File: rtl/sti_dac_multibank_scatter.sv
// sti_pixel_scatter: packs the serial stream into pixels and scatters
// them over the odd/even memory pairs; on end_flag pads the remaining
// locations with zero pixels.
//   so_data/so_valid : serial stream from the transmitter
//   end_flag         : one-cycle pulse after the last bit of the last word
//   oem_addr/dataout : registered write address/data
//   odd_wr/even_wr   : one-cycle write strobes, cycle after addr/data
//   oem_finish       : sticky, every location has been written
module sti_pixel_scatter
  import sti_dac_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 so_data,
  input  logic                 so_valid,
  input  logic                 end_flag,
  output logic [ADDR_W-1:0]    oem_addr,
  output logic [PIX_W-1:0]     oem_dataout,
  output logic [NUM_BANKS-1:0] odd_wr,
  output logic [NUM_BANKS-1:0] even_wr,
  output logic                 oem_finish
);

  logic [PIX_W-1:0]     pix_q;
  logic [BITC_W-1:0]    bitc_q;
  logic [PCNT_W-1:0]    p_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [PIX_W-1:0]     data_q;
  logic [BANK_W-1:0]    bank_q;
  logic                 odd_q;
  logic                 pend_q;
  logic                 flush_q;
  logic                 finish_q;
  logic [NUM_BANKS-1:0] odd_wr_q;
  logic [NUM_BANKS-1:0] even_wr_q;

  logic [PIX_W-1:0] pix_d;
  logic             pix_done;
  logic             flush_go;
  logic             wr_go;
  map_t             map_d;

  always_comb begin
    pix_d    = {pix_q[PIX_W-2:0], so_data};
    pix_done = so_valid && (bitc_q == BITC_W'(PIX_W - 1));
    // Zero pixels are only queued while no write is in flight, which
    // keeps addr/data stable through the strobe cycle.
    flush_go = flush_q && !pend_q && (p_q < TOTAL_P);
    wr_go    = (pix_done && (p_q < TOTAL_P)) || flush_go;
    map_d    = map_pixel(p_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q     <= '0;
      bitc_q    <= '0;
      p_q       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      bank_q    <= '0;
      odd_q     <= 1'b0;
      pend_q    <= 1'b0;
      flush_q   <= 1'b0;
      finish_q  <= 1'b0;
      odd_wr_q  <= '0;
      even_wr_q <= '0;
    end else begin
      if (so_valid) begin
        pix_q  <= pix_done ? '0 : pix_d;
        bitc_q <= pix_done ? '0 : bitc_q + BITC_W'(1);
      end
      if (end_flag) flush_q <= 1'b1;

      odd_wr_q  <= '0;
      even_wr_q <= '0;
      if (pend_q) begin
        if (odd_q) odd_wr_q[bank_q]  <= 1'b1;
        else       even_wr_q[bank_q] <= 1'b1;
      end
      pend_q <= wr_go;
      if (wr_go) begin
        addr_q <= map_d.addr;
        bank_q <= map_d.bank;
        odd_q  <= map_d.odd;
        data_q <= flush_go ? '0 : pix_d;
        p_q    <= p_q + PCNT_W'(1);
      end

      if ((p_q == TOTAL_P) && !pend_q) finish_q <= 1'b1;
    end
  end

  assign oem_addr    = addr_q;
  assign oem_dataout = data_q;
  assign odd_wr      = odd_wr_q;
  assign even_wr     = even_wr_q;
  assign oem_finish  = finish_q;

endmodule

// File: rtl/sti_dac_multibank.sv
// sti_dac_multibank: parallel-to-serial transmitter with ready/load
// handshake feeding a pixel packer that fills NUM_BANKS odd/even memories.
//   load/pi_*   : parallel word and per-word framing controls
//   pi_ready    : may accept a load
//   so_data/so_valid : serial output
//   oem_*/odd_wr/even_wr/oem_finish : memory write side (see scatter)
//
//   state    | meaning
//   ST_IDLE  | pi_ready=1, waiting for load
//   ST_SHIFT | shifting frame out, so_valid=1
//   ST_FLUSH | last word sent, scatter pads remaining pixels
//   ST_DONE  | all locations written, held until reset
module sti_dac_multibank
  import sti_dac_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_W-1:0]    pi_data,
  input  logic [1:0]           pi_length,
  input  logic                 pi_fill,
  input  logic                 pi_msb,
  input  logic                 pi_low,
  input  logic                 pi_end,
  output logic                 pi_ready,
  output logic                 so_data,
  output logic                 so_valid,
  output logic [ADDR_W-1:0]    oem_addr,
  output logic [PIX_W-1:0]     oem_dataout,
  output logic [NUM_BANKS-1:0] odd_wr,
  output logic [NUM_BANKS-1:0] even_wr,
  output logic                 oem_finish
);

  state_e             state_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               end_q;
  logic               end_flag_q;
  logic               pi_ready_q;
  logic               so_data_q;
  logic               so_valid_q;
  logic [FRAME_W-1:0] frame_d;

  always_comb frame_d = build_frame(pi_data, pi_length, pi_fill, pi_low, pi_msb);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      end_q      <= 1'b0;
      end_flag_q <= 1'b0;
      pi_ready_q <= 1'b1;
      so_data_q  <= 1'b0;
      so_valid_q <= 1'b0;
    end else begin
      end_flag_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (load && pi_ready_q) begin
            so_valid_q <= 1'b1;
            so_data_q  <= frame_d[FRAME_W-1];
            shreg_q    <= frame_d << 1;
            cnt_q      <= frame_len(pi_length) - LEN_W'(1);
            end_q      <= pi_end;
            pi_ready_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            so_valid_q <= 1'b0;
            so_data_q  <= 1'b0;
            if (end_q) begin
              end_flag_q <= 1'b1;
              state_q    <= ST_FLUSH;
            end else begin
              pi_ready_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end else begin
            so_data_q <= shreg_q[FRAME_W-1];
            shreg_q   <= shreg_q << 1;
            cnt_q     <= cnt_q - LEN_W'(1);
          end
        end
        ST_FLUSH: if (oem_finish) state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_DONE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign pi_ready = pi_ready_q;
  assign so_data  = so_data_q;
  assign so_valid = so_valid_q;

  sti_pixel_scatter u_scatter (
    .clk         (clk),
    .reset       (reset),
    .so_data     (so_data_q),
    .so_valid    (so_valid_q),
    .end_flag    (end_flag_q),
    .oem_addr    (oem_addr),
    .oem_dataout (oem_dataout),
    .odd_wr      (odd_wr),
    .even_wr     (even_wr),
    .oem_finish  (oem_finish)
  );

endmodule
